// File: rtl/ila_readout_engine.sv
// ila_readout_engine
//
// Streams a finished logic-analyzer capture out of the circular capture
// buffer onto a byte-wide valid/ready link. After `start`, all DEPTH samples
// are read in chronological order beginning at `base_ptr`, wrapping at the
// end of the buffer. Each sample goes out least-significant byte first.
//
// Ports:
//   clk       sole clock, also clocks the capture buffer read port
//   rst       synchronous active-high reset
//   start     one-cycle readout request, honoured only when idle
//   base_ptr  address of the oldest sample, captured when start is taken
//   abort     cancels a readout in progress (no done pulse)
//   busy      high while a readout is in progress
//   done      one-cycle pulse after the final byte handshake
//   rd_en     capture buffer read enable
//   rd_addr   capture buffer read address
//   rd_data   capture buffer read data, valid one cycle after rd_en
//   tx_valid  output byte valid
//   tx_ready  sink ready
//   tx_data   output byte
//   tx_last   marks the final byte of the final sample

module ila_readout_engine #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int DEPTH        = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(DEPTH)-1:0]  base_ptr,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [$clog2(DEPTH)-1:0]  rd_addr,
  input  logic [SAMPLE_WIDTH-1:0]   rd_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_last
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int BYTES     = (SAMPLE_WIDTH + 7) / 8;
  localparam int SHIFT_W   = BYTES * 8;
  localparam int BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BIDX_W-1:0]  BIDX_LAST   = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_BITS:0] SCOUNT_LAST = (ADDR_BITS + 1)'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  logic [1:0]           state_reg,  state_next;
  logic [ADDR_BITS-1:0] addr_reg,   addr_next;
  logic [ADDR_BITS:0]   scount_reg, scount_next;
  logic [BIDX_W-1:0]    bidx_reg,   bidx_next;
  logic [SHIFT_W-1:0]   shift_reg,  shift_next;
  logic                 done_reg,   done_next;

  // Read data zero-extended to a whole number of bytes so the top byte of a
  // partial-width sample carries zeros in its unused bits.
  logic [SHIFT_W-1:0] rd_data_padded;

  for (genvar gi = 0; gi < SHIFT_W; gi++) begin : g_pad
    if (gi < SAMPLE_WIDTH) begin : g_bit
      assign rd_data_padded[gi] = rd_data[gi];
    end else begin : g_zero
      assign rd_data_padded[gi] = 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    scount_next = scount_reg;
    bidx_next   = bidx_reg;
    shift_next  = shift_reg;
    done_next   = 1'b0;

    if (abort) begin
      // Abort wins over start and over a handshake in the same cycle.
      if (state_reg != ST_IDLE) begin
        state_next = ST_IDLE;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_next   = base_ptr;
            scount_next = '0;
            bidx_next   = '0;
            state_next  = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_next = ST_LATCH;
        end
        ST_LATCH: begin
          // rd_data is valid now, one cycle after the FETCH read.
          shift_next = rd_data_padded;
          bidx_next  = '0;
          state_next = ST_SEND;
        end
        ST_SEND: begin
          if (tx_ready) begin
            shift_next = shift_reg >> 8;
            bidx_next  = bidx_reg + 1'b1;
            if (bidx_reg == BIDX_LAST) begin
              if (scount_reg == SCOUNT_LAST) begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
              end else begin
                scount_next = scount_reg + 1'b1;
                addr_next   = addr_reg + 1'b1; // natural wrap at DEPTH
                state_next  = ST_FETCH;
              end
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      scount_reg <= '0;
      bidx_reg   <= '0;
      shift_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      scount_reg <= scount_next;
      bidx_reg   <= bidx_next;
      shift_reg  <= shift_next;
      done_reg   <= done_next;
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign rd_en    = (state_reg == ST_FETCH);
  assign rd_addr  = addr_reg;
  assign tx_valid = (state_reg == ST_SEND);
  assign tx_data  = shift_reg[7:0];
  assign tx_last  = (state_reg == ST_SEND) && (bidx_reg == BIDX_LAST) &&
                    (scount_reg == SCOUNT_LAST);

endmodule

// File: tb/tb_ila_readout_engine.sv
`timescale 1ns/1ps
// Bench for ila_readout_engine. A transaction-level model (expected byte and
// address queues built from the buffer contents when a start is taken) is
// compared against the 12-bit/8-deep instance every cycle; a 32-bit/4-deep
// instance pins the cycle timing with literal expectations.
module tb_ila_readout_engine;

  localparam int SW   = 12;
  localparam int DP   = 8;
  localparam int AB   = 3;
  localparam int NB   = 2;
  localparam int SW32 = 32;
  localparam int DP32 = 4;
  localparam int AB32 = 2;
  localparam int NB32 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // main instance signals
  logic          rst, start, abort, tx_ready;
  logic [AB-1:0] base_ptr;
  logic          busy, done, rd_en, tx_valid, tx_last;
  logic [AB-1:0] rd_addr;
  logic [SW-1:0] rd_data;
  logic [7:0]    tx_data;

  // timing instance signals
  logic            s_start, s_abort, s_tx_ready;
  logic [AB32-1:0] s_base;
  logic            s_busy, s_done, s_rd_en, s_tx_valid, s_tx_last;
  logic [AB32-1:0] s_rd_addr;
  logic [SW32-1:0] s_rd_data;
  logic [7:0]      s_tx_data;

  ila_readout_engine #(.SAMPLE_WIDTH(SW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .base_ptr(base_ptr), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last)
  );

  ila_readout_engine #(.SAMPLE_WIDTH(SW32), .DEPTH(DP32)) dut32 (
    .clk(clk), .rst(rst), .start(s_start), .base_ptr(s_base), .abort(s_abort),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
    .tx_data(s_tx_data), .tx_last(s_tx_last)
  );

  // capture buffers with one-cycle registered read
  logic [SW-1:0]   mem   [DP];
  logic [SW32-1:0] mem32 [DP32];
  always @(posedge clk) if (rd_en)   rd_data   <= mem[rd_addr];
  always @(posedge clk) if (s_rd_en) s_rd_data <= mem32[s_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] byte_q[$];
  int         addr_q[$];
  bit         m_busy = 1'b0, m_done = 1'b0, rst_seen = 1'b0, stalled = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  logic [7:0] cap_q[$];
  int         addr_log[$];
  int         last_cnt = 0, last_idx = -1, done_cnt = 0;

  always @(posedge clk) begin
    m_done   = 1'b0;
    stalled  = 1'b0;
    rst_seen = 1'b0;
    if (rst) begin
      byte_q.delete(); addr_q.delete(); m_busy = 1'b0; rst_seen = 1'b1;
    end else if (abort && m_busy) begin
      byte_q.delete(); addr_q.delete(); m_busy = 1'b0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        for (int s = 0; s < DP; s++) begin
          int a;
          logic [15:0] w;
          a = (int'(base_ptr) + s) % DP;
          w = 16'(mem[a]);
          addr_q.push_back(a);
          for (int b = 0; b < NB; b++) byte_q.push_back(8'(w >> (8 * b)));
        end
        m_busy = 1'b1;
      end
    end else if (tx_valid && tx_ready) begin
      cap_q.push_back(tx_data);
      if (tx_last) begin last_cnt++; last_idx = cap_q.size() - 1; end
      if (byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() == 0) begin m_busy = 1'b0; m_done = 1'b1; end
    end else if (tx_valid) begin
      stalled = 1'b1; hold_data = tx_data; hold_last = tx_last;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (done) done_cnt++;
    if (rst_seen) begin
      check("rst_busy", busy, 0);     check("rst_done", done, 0);
      check("rst_rd_en", rd_en, 0);   check("rst_rd_addr", rd_addr, 0);
      check("rst_tx_valid", tx_valid, 0); check("rst_tx_data", tx_data, 0);
      check("rst_tx_last", tx_last, 0);
    end
    if (stalled) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, hold_data);
      check("stall_last", tx_last, hold_last);
    end
    if (rd_en) begin
      addr_log.push_back(int'(rd_addr));
      if (addr_q.size() == 0) check("rd_en_unexpected", rd_en, 0);
      else begin
        check("rd_addr", rd_addr, addr_q[0]);
        void'(addr_q.pop_front());
      end
    end
    if (tx_valid) begin
      if (byte_q.size() == 0) check("tx_valid_unexpected", tx_valid, 0);
      else begin
        check("tx_data", tx_data, byte_q[0]);
        check("tx_last", tx_last, byte_q.size() == 1);
      end
    end
    if (!m_busy) begin
      check("idle_rd_en", rd_en, 0);
      check("idle_tx_valid", tx_valid, 0);
    end
  end

  // ---------------- timing instance monitor ----------------
  int         s_rd_cyc[$];
  int         s_rd_adr[$];
  int         s_first_valid = -1, s_done_cyc = -1, s_last_cnt = 0, s_last_idx = -1;
  logic [7:0] s_cap[$];

  always @(negedge clk) begin
    if (s_rd_en) begin s_rd_cyc.push_back(ecnt); s_rd_adr.push_back(int'(s_rd_addr)); end
    if (s_tx_valid) begin
      if (s_first_valid < 0) s_first_valid = ecnt;
      s_cap.push_back(s_tx_data);
      if (s_tx_last) begin s_last_cnt++; s_last_idx = s_cap.size() - 1; end
    end
    if (s_done && s_done_cyc < 0) s_done_cyc = ecnt;
  end

  // ---------------- stimulus ----------------
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic tick();
    @(negedge clk);
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  endtask

  task automatic pulse_start(input int base);
    start = 1'b1;
    base_ptr = AB'(base);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    check("done_timeout", done, 1);
    $display("[TB] readout first_addr=%0d bytes=%0d lasts=%0d", 
             (addr_log.size() > 0) ? addr_log[0] : -1, cap_q.size(), last_cnt);
  endtask

  task automatic clear_logs();
    cap_q.delete(); addr_log.delete();
    last_cnt = 0; last_idx = -1; done_cnt = 0;
  endtask

  task automatic check_full_stream(string name, int first_addr, int ndone);
    check({name, "_bytes"}, cap_q.size(), DP * NB);
    check({name, "_first_addr"}, (addr_log.size() > 0) ? addr_log[0] : -1, first_addr);
    check({name, "_last_cnt"}, last_cnt, 1);
    check({name, "_last_idx"}, last_idx, DP * NB - 1);
    check({name, "_done_cnt"}, done_cnt, ndone);
  endtask

  logic [7:0] ref1[$];
  int exp_addr[8] = '{5, 6, 7, 0, 1, 2, 3, 4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_ptr = '0; tx_ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_tx_ready = 1'b1; s_base = '0;
    for (int k = 0; k < DP; k++) mem[k] = SW'(12'hA00 + k);
    for (int k = 0; k < DP32; k++) mem32[k] = $urandom;

    while (ecnt < 3) tick();
    rst = 1'b0;

    // cycle timing on the 32-bit instance: start in cycle 10
    while (ecnt < 10) tick();
    s_start = 1'b1; s_base = 2'd1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (s_done_cyc < 0 && n < 100) begin tick(); n++; end
    check("t32_rd_count", s_rd_cyc.size(), DP32);
    for (int i = 0; i < DP32; i++) begin
      check("t32_rd_cycle", (i < s_rd_cyc.size()) ? s_rd_cyc[i] : -1, 11 + 6 * i);
      check("t32_rd_addr", (i < s_rd_adr.size()) ? s_rd_adr[i] : -1, (1 + i) % DP32);
    end
    check("t32_first_valid", s_first_valid, 13);
    check("t32_done_cycle", s_done_cyc, 35);
    check("t32_bytes", s_cap.size(), DP32 * NB32);
    for (int s = 0; s < DP32; s++) begin
      for (int b = 0; b < NB32; b++) begin
        logic [31:0] w;
        int idx;
        w = mem32[(1 + s) % DP32];
        idx = s * NB32 + b;
        check("t32_byte", (idx < s_cap.size()) ? s_cap[idx] : 9'h100, w[8 * b +: 8]);
      end
    end
    check("t32_last_cnt", s_last_cnt, 1);
    check("t32_last_idx", s_last_idx, DP32 * NB32 - 1);
    check("t32_busy_after", s_busy, 0);
    $display("[TB] readout32 rd_en@%0d first_valid@%0d done@%0d bytes=%0d",
             (s_rd_cyc.size() > 0) ? s_rd_cyc[0] : -1, s_first_valid, s_done_cyc, s_cap.size());

    // pointer wrap and byte order
    ready_mode = 0;
    clear_logs();
    pulse_start(5);
    wait_done();
    tick(); tick();
    check_full_stream("wrap", 5, 1);
    check("wrap_addr_count", addr_log.size(), DP);
    for (int i = 0; i < DP; i++)
      check("wrap_addr", (i < addr_log.size()) ? addr_log[i] : -1, exp_addr[i]);
    check("wrap_byte0", (cap_q.size() > 3) ? cap_q[0] : 9'h100, 8'h05);
    check("wrap_byte1", (cap_q.size() > 3) ? cap_q[1] : 9'h100, 8'h0A);
    check("wrap_byte2", (cap_q.size() > 3) ? cap_q[2] : 9'h100, 8'h06);
    check("wrap_byte3", (cap_q.size() > 3) ? cap_q[3] : 9'h100, 8'h0A);
    ref1 = cap_q;

    // backpressure: same stream under random ready
    ready_mode = 1;
    clear_logs();
    pulse_start(5);
    wait_done();
    tick();
    check_full_stream("bp", 5, 1);
    for (int i = 0; i < DP * NB; i++)
      check("bp_same_byte", (i < cap_q.size()) ? cap_q[i] : 9'h100,
            (i < ref1.size()) ? ref1[i] : 9'h1FF);

    // start while busy is ignored
    for (int k = 0; k < DP; k++) mem[k] = SW'($urandom);
    clear_logs();
    pulse_start(6);
    repeat (9) tick();
    start = 1'b1; base_ptr = 3'd2;
    tick();
    start = 1'b0;
    wait_done();
    tick();
    check_full_stream("busy_start", 6, 1);

    // abort while stalled in SEND
    ready_mode = 2;
    clear_logs();
    pulse_start(3);
    n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    check("abort_reach_send", tx_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    ready_mode = 1;
    repeat (3) tick();
    check("abort_no_done", done_cnt, 0);
    clear_logs();
    pulse_start(1);
    wait_done();
    tick();
    check_full_stream("after_abort", 1, 1);

    // reset during LATCH
    ready_mode = 0;
    clear_logs();
    pulse_start(4);
    check("rst_in_fetch", rd_en, 1);
    tick();                       // LATCH cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_valid", tx_valid, 0);
    check("rstmid_rd_addr", rd_addr, 0);
    ready_mode = 1;
    clear_logs();
    pulse_start(0);
    wait_done();
    tick();
    check_full_stream("after_rst", 0, 1);

    // back-to-back: start accepted in the done cycle
    ready_mode = 0;
    clear_logs();
    pulse_start(7);
    wait_done();
    start = 1'b1; base_ptr = 3'd2;
    tick();
    start = 1'b0;
    check("b2b_accepted", busy, 1);
    wait_done();
    tick();
    check("b2b_bytes", cap_q.size(), 2 * DP * NB);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_second_addr", (addr_log.size() > DP) ? addr_log[DP] : -1, 2);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ila_readout_engine.md
# ila_readout_engine

Streams a completed logic-analyzer capture out of the capture buffer to a byte-wide host link. It sits between the capture buffer's read port and the debug transport (UART/JTAG bridge). Once the capture state machine reports DONE, firmware pulses `start` with the capture's base pointer. The block then reads all DEPTH samples in chronological order, wrapping around the circular buffer, and serializes each sample LSB-byte-first over a valid/ready stream.

## Interface
Parameters:
- SAMPLE_WIDTH, 32: width of one capture-buffer word in bits; legal range 1 to 1024.
- DEPTH, 1024: number of samples in the capture buffer; must be a power of two and at least 2.
- ADDR_BITS (localparam), $clog2(DEPTH): width of a buffer pointer.
- BYTES (localparam), (SAMPLE_WIDTH+7)/8: bytes sent per sample.

Ports:
- clk  in  1  sole clock; also clocks the capture buffer read port.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin readout; ignored unless idle.
- base_ptr  in  ADDR_BITS  oldest sample address; sampled only when `start` is accepted.
- abort  in  1  cancels a readout in progress.
- busy  out  1  high from the cycle after `start` is accepted until return to idle.
- done  out  1  one-cycle pulse when the final byte has been accepted.
- rd_en  out  1  capture-buffer read enable.
- rd_addr  out  ADDR_BITS  capture-buffer read address.
- rd_data  in  SAMPLE_WIDTH  read data; valid exactly one cycle after `rd_en`.
- tx_valid  out  1  output byte valid.
- tx_ready  in  1  sink ready.
- tx_data  out  8  output byte.
- tx_last  out  1  high with the final byte of the final sample.

## Operation
- The block has four states: IDLE, FETCH, LATCH and SEND.
- IDLE:
  - `start` latches `base_ptr` into `rd_addr`.
  - `start` clears the sample counter `scount` (ADDR_BITS+1 bits) and the byte index `bidx`.
  - The state then moves to FETCH.
- FETCH:
  - `rd_en`=1 for exactly one cycle, with `rd_addr` equal to the current pointer.
  - The state moves to LATCH.
- LATCH:
  - `rd_data` is registered into the shift register. Bits above SAMPLE_WIDTH are zero-padded to BYTES*8.
  - `bidx` is cleared to 0 and the state moves to SEND.
- SEND:
  - `tx_valid`=1 and `tx_data` = shift register bits [7:0].
  - On `tx_valid && tx_ready`:
    - The shift register shifts right by 8 and `bidx` increments.
    - If `bidx`==BYTES-1, the sample is complete:
      - If `scount`==DEPTH-1, go to IDLE and pulse `done`.
      - Otherwise increment `scount`, set `rd_addr` to `rd_addr`+1 modulo DEPTH (natural ADDR_BITS wrap), and go to FETCH.
- `tx_last` = (state==SEND) && (`bidx`==BYTES-1) && (`scount`==DEPTH-1).
- Byte order on the link: sample 0 (at `base_ptr`) first; within a sample, least-significant byte first.
- The total stream length is DEPTH*BYTES bytes.
- `tx_data` and `tx_last` stay stable while `tx_valid` is high and `tx_ready` is low.
- `abort`:
  - In any non-IDLE state, `abort` forces IDLE on the next edge and deasserts `tx_valid`, `rd_en` and `busy`.
  - `done` is not pulsed.
  - `abort` is the only case where `tx_valid` may drop without a handshake.
  - `abort` has priority over `start` and over a simultaneous handshake.
- `start` while busy: ignored, with no effect on the pointer or the counters.
- `rst`: all state returns to IDLE.
  - Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `tx_valid`=0, `tx_data`=0, `tx_last`=0.
  - `rst` overrides `abort` and `start`.

## Timing
- `start` accepted at edge T:
  - `busy`=1 and `rd_en`=1 (FETCH) in the cycle after T.
  - LATCH in the next cycle.
  - The first `tx_valid` appears 3 cycles after `start` is sampled.
- Per-sample overhead is 2 cycles (FETCH and LATCH) with no `tx_valid`.
- With `tx_ready` held high, one sample takes BYTES+2 cycles.
- `done` is high in the cycle after the final handshake; `busy` is low in that same cycle.
- A new `start` is accepted in the cycle `done` is high.
- Read latency is fixed at 1 cycle. No pipelining across samples is required.

## Test plan
- Pointer wrap and byte order:
  - Setup: SAMPLE_WIDTH=12, DEPTH=8, buffer word k = 0xA00+k, `base_ptr`=5, `tx_ready`=1.
  - Required: read addresses 5,6,7,0,1,2,3,4, 16 bytes total.
  - Bytes begin 0x05,0x0A,0x06,0x0A. `tx_last` appears only on the 16th byte.
  - `done` pulses exactly once, one cycle after that byte.
- Backpressure:
  - Stimulus: toggle `tx_ready` pseudo-randomly.
  - Required: the byte sequence is identical to the previous test, and `tx_data` and `tx_last` never change while a byte is stalled.
- Cycle timing:
  - Stimulus: SAMPLE_WIDTH=32, `start` at cycle 10, `tx_ready`=1.
  - Required: `rd_en` at cycle 11, first `tx_valid` at cycle 13, 6 cycles per sample.
- `start` while busy:
  - Stimulus: pulse `start` with `base_ptr`=2 in the middle of a readout.
  - Required: the stream is unchanged and `done` occurs at the expected count.
- Abort:
  - Stimulus: assert `abort` while stalled in SEND.
  - Required: next cycle `tx_valid`=0 and `busy`=0, with no `done`.
  - A following `start` produces a full, correct stream from its `base_ptr`.
- Reset mid-stream:
  - Stimulus: assert `rst` during LATCH.
  - Required: next cycle all outputs are at their reset values; the block then operates normally.
